// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage definitions: datapath width, register address width,
// default buffer depth and the effective write-enable rule.
package wb_stage_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_DEPTH   = 2;

  // Writes to x0 are architecturally discarded, so they never enable the port.
  function automatic logic eff_wen(input logic                  wen,
                                   input logic [REG_ADDR_W-1:0] addr);
    return wen && (addr != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with push/pop/flush. The storage array and a
// per-slot valid mask are exported so the parent can search in-flight entries.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 70
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_head_data,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH)-1:0]     o_head,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_entries,
  output logic [DEPTH-1:0]             o_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PW-1:0]               r_head;
  logic [PW-1:0]               r_tail;
  logic [CW-1:0]               r_count;
  logic [PW-1:0]               w_off;

  // Pointer and occupancy update; reset and flush both empty the buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since the valid mask gates all reads.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && i_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    w_off   = '0;
    o_valid = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_off      = PW'(i) - r_head;
      o_valid[i] = CW'(w_off) < r_count;
    end
  end

  assign o_head_data = r_mem[r_head];
  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head      = r_head;
  assign o_entries   = r_mem;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers execute results, drains them into the register-file
// write port, forwards in-flight results to decode and counts retirements.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_in_rd_wen,
  input  logic [REG_ADDR_W-1:0] i_in_rd_addr,
  input  logic [XLEN-1:0]       i_in_rd_data,
  input  logic                  i_in_word,
  input  logic                  i_rf_busy,
  output logic                  o_rf_wen,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0]       o_rf_wdata,
  input  logic [REG_ADDR_W-1:0] i_fwd_raddr,
  output logic                  o_fwd_hit,
  output logic [XLEN-1:0]       o_fwd_data,
  output logic [63:0]           o_commit_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 1 + REG_ADDR_W + XLEN;

  logic                        w_accept;
  logic                        w_pop;
  logic [XLEN-1:0]             w_data;
  logic [EW-1:0]               w_entry_in;
  logic [EW-1:0]               w_head_entry;
  logic [CW-1:0]               w_count;
  logic                        w_full;
  logic                        w_empty;
  logic [PW-1:0]               w_head;
  logic [DEPTH-1:0][EW-1:0]    w_entries;
  logic [DEPTH-1:0]            w_valid;
  logic [PW-1:0]               w_idx;
  logic [EW-1:0]               w_cand;

  logic                        r_rf_wen;
  logic [REG_ADDR_W-1:0]       r_rf_waddr;
  logic [XLEN-1:0]             r_rf_wdata;
  logic [63:0]                 r_commit_cnt;

  // Ready comes only from stored occupancy, never from this cycle's pop.
  assign o_in_ready = (w_count < CW'(DEPTH));
  assign w_accept   = i_in_valid && o_in_ready && !i_flush;
  assign w_pop      = !w_empty && !i_rf_busy && !i_flush;

  assign w_data     = i_in_word ? {{(XLEN-32){i_in_rd_data[31]}}, i_in_rd_data[31:0]}
                                : i_in_rd_data;
  assign w_entry_in = {eff_wen(i_in_rd_wen, i_in_rd_addr), i_in_rd_addr, w_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .i_push      (w_accept),
    .i_pop       (w_pop),
    .i_data      (w_entry_in),
    .o_head_data (w_head_entry),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_entries   (w_entries),
    .o_valid     (w_valid)
  );

  // Registered write port and retirement counter; idle cycles drop wen only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rf_wen     <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_commit_cnt <= '0;
    end else if (w_pop) begin
      r_rf_wen     <= w_head_entry[EW-1];
      r_rf_waddr   <= w_head_entry[XLEN +: REG_ADDR_W];
      r_rf_wdata   <= w_head_entry[XLEN-1:0];
      r_commit_cnt <= r_commit_cnt + 64'd1;
    end else begin
      r_rf_wen     <= 1'b0;
    end
  end

  // Forwarding: rf register is oldest, then head..tail-1; later matches win.
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    w_idx      = '0;
    w_cand     = '0;
    if (i_fwd_raddr != '0) begin
      if (r_rf_wen && (r_rf_waddr == i_fwd_raddr)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = r_rf_wdata;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
        w_idx  = w_head + PW'(k);
        w_cand = w_entries[w_idx];
        if (w_valid[w_idx] && w_cand[EW-1] && (w_cand[XLEN +: REG_ADDR_W] == i_fwd_raddr)) begin
          o_fwd_hit  = 1'b1;
          o_fwd_data = w_cand[XLEN-1:0];
        end
      end
    end
  end

  assign o_rf_wen     = r_rf_wen;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_commit_cnt = r_commit_cnt;

  // Full flag and occupancy must always agree.
  a_full_consistent: assert property (@(posedge i_clk) disable iff (i_rst)
    w_full == (w_count == CW'(DEPTH)));

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: inputs change and outputs are sampled on the
// falling edge, away from the rising active edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_rd_wen;
  logic [4:0]  in_rd_addr;
  logic [63:0] in_rd_data;
  logic        in_word;
  logic        rf_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [63:0] commit_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .DEPTH (2),
    .XLEN  (64)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_rd_wen  (in_rd_wen),
    .i_in_rd_addr (in_rd_addr),
    .i_in_rd_data (in_rd_data),
    .i_in_word    (in_word),
    .i_rf_busy    (rf_busy),
    .o_rf_wen     (rf_wen),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .i_fwd_raddr  (fwd_raddr),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_data   (fwd_data),
    .o_commit_cnt (commit_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one result for a single edge; caller guarantees in_ready is high.
  task automatic push_one(input logic wen, input logic [4:0] addr, input logic [63:0] data,
                          input logic word);
    in_valid   = 1'b1;
    in_rd_wen  = wen;
    in_rd_addr = addr;
    in_rd_data = data;
    in_word    = word;
    step();
    in_valid   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_rd_wen  = 1'b0;
    in_rd_addr = '0;
    in_rd_data = '0;
    in_word    = 1'b0;
    rf_busy    = 1'b0;
    fwd_raddr  = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_wen",    {63'd0, rf_wen},   64'd0);
    check("rst_waddr",  {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata",  rf_wdata,          64'd0);
    check("rst_commit", commit_cnt,        64'd0);
    check("rst_ready",  {63'd0, in_ready}, 64'd1);

    // Single accept: buffered one cycle, visible on the port the next
    push_one(1'b1, 5'd5, 64'h1234, 1'b0);
    fwd_raddr = 5'd5;
    #1;
    check("t1_no_bypass", {63'd0, rf_wen},  64'd0);
    check("t1_fwd_hit",   {63'd0, fwd_hit}, 64'd1);
    check("t1_fwd_data",  fwd_data,         64'h1234);
    step();
    check("t1_wen",    {63'd0, rf_wen},   64'd1);
    check("t1_waddr",  {59'd0, rf_waddr}, 64'd5);
    check("t1_wdata",  rf_wdata,          64'h1234);
    check("t1_commit", commit_cnt,        64'd1);

    // W-type sign extension
    push_one(1'b1, 5'd3, 64'h0000_0000_8000_0001, 1'b1);
    step();
    check("t2_waddr",  {59'd0, rf_waddr}, 64'd3);
    check("t2_wdata",  rf_wdata,          64'hFFFF_FFFF_8000_0001);
    check("t2_commit", commit_cnt,        64'd2);

    // x0 write retires but never enables the port
    push_one(1'b1, 5'd0, 64'hDEAD, 1'b0);
    fwd_raddr = 5'd0;
    #1;
    check("t3_fwd_x0", {63'd0, fwd_hit}, 64'd0);
    step();
    check("t3_wen",    {63'd0, rf_wen}, 64'd0);
    check("t3_commit", commit_cnt,      64'd3);

    // Backpressure: two accepts fill the buffer, third is held by the sender
    rf_busy    = 1'b1;
    in_valid   = 1'b1;
    in_rd_wen  = 1'b1;
    in_word    = 1'b0;
    in_rd_addr = 5'd1;
    in_rd_data = 64'h11;
    step();
    check("t4_ready1", {63'd0, in_ready}, 64'd1);
    in_rd_addr = 5'd2;
    in_rd_data = 64'h22;
    step();
    check("t4_full", {63'd0, in_ready}, 64'd0);
    in_rd_addr = 5'd3;
    in_rd_data = 64'h33;
    fwd_raddr  = 5'd2;
    #1;
    check("t4_fwd_hit",  {63'd0, fwd_hit}, 64'd1);
    check("t4_fwd_data", fwd_data,         64'h22);
    step();
    check("t4_held_ready", {63'd0, in_ready}, 64'd0);
    check("t4_held_wen",   {63'd0, rf_wen},   64'd0);
    rf_busy = 1'b0;
    step();
    check("t4_w1_wen",   {63'd0, rf_wen},   64'd1);
    check("t4_w1_addr",  {59'd0, rf_waddr}, 64'd1);
    check("t4_ready_again", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("t4_w2_wen",  {63'd0, rf_wen},   64'd1);
    check("t4_w2_addr", {59'd0, rf_waddr}, 64'd2);
    step();
    check("t4_w3_wen",  {63'd0, rf_wen},   64'd1);
    check("t4_w3_addr", {59'd0, rf_waddr}, 64'd3);
    check("t4_w3_data", rf_wdata,          64'h33);
    step();
    check("t4_idle_wen", {63'd0, rf_wen}, 64'd0);
    check("t4_commit",   commit_cnt,      64'd6);

    // Forwarding priority: buffered B beats A sitting in the rf register
    push_one(1'b1, 5'd7, 64'hAAAA, 1'b0);
    push_one(1'b1, 5'd7, 64'hBBBB, 1'b0);
    fwd_raddr = 5'd7;
    #1;
    check("t5_rf_has_a", rf_wdata,          64'hAAAA);
    check("t5_fwd_hit",  {63'd0, fwd_hit},  64'd1);
    check("t5_fwd_b",    fwd_data,          64'hBBBB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("t5_flush_wen",  {63'd0, rf_wen},  64'd0);
    check("t5_flush_hit",  {63'd0, fwd_hit}, 64'd0);
    check("t5_flush_data", fwd_data,         64'd0);
    check("t5_commit",     commit_cnt,       64'd7);
    step();
    check("t5_nothing_left", {63'd0, rf_wen}, 64'd0);

    // Flush with a concurrent valid while two entries are buffered
    rf_busy = 1'b1;
    push_one(1'b1, 5'd8, 64'h81, 1'b0);
    push_one(1'b1, 5'd9, 64'h91, 1'b0);
    fwd_raddr = 5'd9;
    #1;
    check("t6_fwd_buffered", {63'd0, fwd_hit}, 64'd1);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_rd_addr = 5'd10;
    in_rd_data = 64'hA1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    fwd_raddr = 5'd10;
    #1;
    check("t6_ready",     {63'd0, in_ready}, 64'd1);
    check("t6_wen",       {63'd0, rf_wen},   64'd0);
    check("t6_not_taken", {63'd0, fwd_hit},  64'd0);
    check("t6_commit",    commit_cnt,        64'd7);
    rf_busy = 1'b0;
    step();
    check("t6_empty_wen", {63'd0, rf_wen}, 64'd0);

    // Reset mid-stream clears buffer, port registers and counter
    rf_busy = 1'b1;
    push_one(1'b1, 5'd4, 64'h44, 1'b0);
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_rd_addr = 5'd6;
    in_rd_data = 64'h66;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    fwd_raddr = 5'd4;
    #1;
    check("t7_waddr",  {59'd0, rf_waddr}, 64'd0);
    check("t7_wdata",  rf_wdata,          64'd0);
    check("t7_commit", commit_cnt,        64'd0);
    check("t7_ready",  {63'd0, in_ready}, 64'd1);
    check("t7_fwd",    {63'd0, fwd_hit},  64'd0);
    rf_busy = 1'b0;
    step();
    check("t7_wen", {63'd0, rf_wen}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback end of the execute datapath: accepts ALU results from the execute stage over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the shared integer register-file write port, stalling while that port is busy.
- Provides a forwarding lookup for in-flight results, plus a retired-result counter for perf/difftest.

Parameters:
- DEPTH, 2, FIFO entries (power of 2, ≥2).
- XLEN, 64, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  drop all buffered results (pipeline redirect).
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept.
- in_rd_wen  in  1  result targets a register.
- in_rd_addr  in  5  destination register.
- in_rd_data  in  XLEN  ALU result.
- in_word  in  1  W-type op: sign-extend bits [31:0].
- rf_busy  in  1  register-file write port taken this cycle.
- rf_wen  out  1  register write enable (registered).
- rf_waddr  out  5  register write address (registered).
- rf_wdata  out  XLEN  register write data (registered).
- fwd_raddr  in  5  decode lookup address.
- fwd_hit  out  1  youngest in-flight write to fwd_raddr exists.
- fwd_data  out  XLEN  data for that write.
- commit_cnt  out  64  retired entries, wraps modulo 2^64.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empty; head/tail/count = 0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0, commit_cnt=0.
  - rst has priority over flush and over all handshakes.
- Handshake:
  - in_ready = (count < DEPTH). It is registered-state derived and never depends combinationally on rf_busy or in_valid.
  - Accept when in_valid && in_ready && !flush.
  - in_valid may drop without acceptance. in_* fields need be stable only in the accepting cycle.
- Accept transform, performed before storage:
  - data = in_word ? {{32{in_rd_data[31]}}, in_rd_data[31:0]} : in_rd_data.
  - Effective wen = in_rd_wen && (in_rd_addr != 0).
  - Entry = {wen, addr, data}.
- Drain:
  - Pop when count>0 && !rf_busy && !flush.
  - On the next edge: rf_wen <= head.wen, rf_waddr <= head.addr, rf_wdata <= head.data, commit_cnt += 1. Entries with wen=0 still pop and count.
  - If no pop: rf_wen <= 0; rf_waddr and rf_wdata hold.
- Latency:
  - Accept at edge N; earliest pop in cycle N; rf_wen high in cycle N+1.
  - Empty-FIFO bypass is not permitted.
  - Sustained throughput is 1/cycle while rf_busy=0.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, in_ready=0 even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. count is held in clog2(DEPTH)+1 bits.
- flush:
  - At the edge, count=0 and the pointers reset.
  - A same-cycle in_valid is not accepted and no pop occurs, so rf_wen=0 in the next cycle.
  - An rf_* write already registered (visible during the flush cycle) is unaffected.
  - commit_cnt is unchanged by flush.
- rf_busy mid-stream: the head is held and nothing is lost. Accepts continue until full.
- Forwarding (combinational):
  - Search scope: the valid FIFO entries plus the rf output register (when rf_wen=1).
  - Match condition: wen=1 && addr==fwd_raddr.
  - Priority is youngest first: tail-1 … head, then the rf output register.
  - fwd_raddr==0 always gives fwd_hit=0. When fwd_hit=0, fwd_data=0.

Decomposition:
- Shared defines header (alongside existing `REG_BUS`/`ZERO_WORD`): XLEN, REG_ADDR_BUS (4:0), WB_DEPTH default.
- One natural sub-module, wb_fifo:
  - Generic DEPTH×(1+5+XLEN) synchronous FIFO with push/pop/flush, count and full/empty.
  - Exposes its entry array and valid mask for the forwarding search.
- wb_stage holds the accept transform, drain/output register, forwarding mux and counter.

Test Plan:
- Reset then single accept:
  - Stimulus: rd=5, data=0x1234, word=0 at edge 1.
  - Required: rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in cycle 2; commit_cnt=1.
- W-type sign-extend:
  - Stimulus: in_rd_data=0x0000_0000_8000_0001, word=1, rd=3.
  - Required: rf_wdata=0xFFFF_FFFF_8000_0001.
- x0 write:
  - Stimulus: rd=0, wen=1, data=0xDEAD.
  - Required: rf_wen stays 0; commit_cnt increments; fwd_hit=0 for raddr 0.
- Backpressure:
  - Stimulus: rf_busy=1 while pushing rd=1,2,3 back-to-back.
  - Required: in_ready=0 after 2 accepts; rd=3 held by sender.
  - Then release rf_busy: writes 1, 2, 3 in consecutive cycles, in order.
- Forwarding priority:
  - Stimulus: buffer rd=7/data=A then rd=7/data=B with rf_busy=1; set fwd_raddr=7.
  - Required: fwd_hit=1, fwd_data=B. After B is discarded by flush: fwd_hit=0, or A if A is already in the rf register.
- Flush plus concurrent valid:
  - Stimulus: 2 entries buffered, flush=1 together with in_valid=1.
  - Required: next cycle count=0, in_ready=1, rf_wen=0; commit_cnt unchanged.
  - Also: rst asserted mid-stream clears everything the next cycle.
